vip_matrix_gen_3x3: RTL and testbench

//  Parametrised 3x3 window generator for the VIP pixel pipeline; successor to the 1-bit matrix generator.

---
 rtl/vip_matrix_gen_3x3.sv | 172 +++++++++++++++++
 tb/tb_vip_matrix_gen_3x3.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_matrix_gen_3x3.sv
// 3x3 sliding-window generator with two inferred line buffers, row/column tracking and border padding.
// Optional macro VIP_MATRIX_BORDER_REPLICATE_EN: replicate edge pixels instead of zero padding.
module vip_matrix_gen_3x3 #(
  parameter int DATA_W    = 1,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_W-1:0]     per_img_data,
  output logic                  matrix_frame_vsync,
  output logic                  matrix_frame_href,
  output logic                  matrix_frame_clken,
  output logic [9*DATA_W-1:0]   matrix_data,
  output logic                  matrix_border
);

  localparam int COL_W = $clog2(IMG_HDISP + 1);
  localparam int ROW_W = $clog2(IMG_VDISP + 1);
  localparam int AW    = $clog2(IMG_HDISP);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              href_prev;
  logic              vsync_prev;
  logic              href_fall;
  logic              vsync_rise;
  logic              accept;

  logic              valid_d1;
  logic [DATA_W-1:0] pix_d1;
  logic [AW-1:0]     col_d1;
  logic [ROW_W-1:0]  row_d1;

  logic [DATA_W-1:0] lb0 [IMG_HDISP];
  logic [DATA_W-1:0] lb1 [IMG_HDISP];
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  logic [DATA_W-1:0] new_col  [3];
  logic [DATA_W-1:0] left_fill [3];
  logic [DATA_W-1:0] win [3][3];
  logic              border_d1;

  logic              vsync_d1;
  logic              href_d1;

  assign href_fall  = href_prev & ~per_frame_href;
  assign vsync_rise = ~vsync_prev & per_frame_vsync;
  assign accept     = per_frame_href & per_frame_clken & (col < COL_W'(IMG_HDISP));

  // Column counts accepted pixels of the line; row counts completed lines and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      href_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      href_prev  <= per_frame_href;
      vsync_prev <= per_frame_vsync;
      if (href_fall)
        col <= '0;
      else if (accept)
        col <= col + COL_W'(1);
      if (vsync_rise)
        row <= '0;
      else if (href_fall && (row != ROW_W'(IMG_VDISP)))
        row <= row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d1 <= 1'b0;
      pix_d1   <= '0;
      col_d1   <= '0;
      row_d1   <= '0;
    end else begin
      valid_d1 <= accept;
      if (accept) begin
        pix_d1 <= per_img_data;
        col_d1 <= col[AW-1:0];
        row_d1 <= row;
      end
    end
  end

  // Line buffers: read in the accept cycle, written one cycle later so the old line is read first.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_rd <= lb0[col[AW-1:0]];
      lb1_rd <= lb1[col[AW-1:0]];
    end
    if (valid_d1) begin
      lb0[col_d1] <= pix_d1;
      lb1[col_d1] <= lb0_rd;
    end
  end

  always_comb begin
    new_col[0] = lb1_rd;
    new_col[1] = lb0_rd;
    new_col[2] = pix_d1;
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
    if (row_d1 == '0) begin
      new_col[0] = pix_d1;
      new_col[1] = pix_d1;
    end else if (row_d1 == ROW_W'(1)) begin
      new_col[0] = lb0_rd;
    end
    for (int r = 0; r < 3; r++)
      left_fill[r] = new_col[r];
`else
    if (row_d1 == '0) begin
      new_col[0] = '0;
      new_col[1] = '0;
    end else if (row_d1 == ROW_W'(1)) begin
      new_col[0] = '0;
    end
    for (int r = 0; r < 3; r++)
      left_fill[r] = '0;
`endif
    border_d1 = (row_d1 < ROW_W'(2)) | (col_d1 < AW'(2));
  end

  // On column 0 the two left columns are refilled, which makes column 1 padding fall out of the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      matrix_border <= 1'b0;
    end else if (valid_d1) begin
      for (int r = 0; r < 3; r++) begin
        win[r][2] <= new_col[r];
        if (col_d1 == '0) begin
          win[r][0] <= left_fill[r];
          win[r][1] <= left_fill[r];
        end else begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
      end
      matrix_border <= border_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d1           <= 1'b0;
      href_d1            <= 1'b0;
      matrix_frame_vsync <= 1'b0;
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
    end else begin
      vsync_d1           <= per_frame_vsync;
      href_d1            <= per_frame_href;
      matrix_frame_vsync <= vsync_d1;
      matrix_frame_href  <= href_d1;
      matrix_frame_clken <= valid_d1;
    end
  end

  assign matrix_data = {win[0][0], win[0][1], win[0][2],
                        win[1][0], win[1][1], win[1][2],
                        win[2][0], win[2][1], win[2][2]};

endmodule

// File: tb/tb_vip_matrix_gen_3x3.sv
// Self-checking bench for vip_matrix_gen_3x3 (8-bit pixels, 4x3 frame) against an image-level window model.
// Honours VIP_MATRIX_BORDER_REPLICATE_EN in the reference model as well.
module tb_vip_matrix_gen_3x3;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk;
  logic        rst;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [7:0]  per_img_data;
  logic        matrix_frame_vsync;
  logic        matrix_frame_href;
  logic        matrix_frame_clken;
  logic [71:0] matrix_data;
  logic        matrix_border;

  int checks = 0;
  int errors = 0;

  // Reference model state: image lines (0 = current, 1 = previous, 2 = two back) and frame position.
  logic [7:0]  hist [3][H];
  int          mcol;
  int          mrow;
  logic        mhref_prev;
  logic        mvs_prev;
  logic [72:0] exp_q [$];
  logic [72:0] obs_q [$];

  vip_matrix_gen_3x3 #(.DATA_W(8), .IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk                (clk),
    .rst                (rst),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_data       (per_img_data),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_data        (matrix_data),
    .matrix_border      (matrix_border)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window for pixel (x,y): tap (x+dx, y+dy), dx,dy in -2..0, with out-of-frame taps padded.
  function automatic logic [72:0] model_window(input int x, input int y);
    logic [71:0] w;
    logic [7:0]  v;
    int          ry;
    int          rx;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ry = y + r - 2;
        rx = x + c - 2;
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
        if (ry < 0) ry = 0;
        if (rx < 0) rx = 0;
        v = hist[y - ry][rx];
`else
        if (ry < 0 || rx < 0)
          v = 8'h00;
        else
          v = hist[y - ry][rx];
`endif
        w[71 - 8*(r*3 + c) -: 8] = v;
      end
    end
    return {((y < 2) || (x < 2)), w};
  endfunction

  task automatic model_reset();
    mcol       = 0;
    mrow       = 0;
    mhref_prev = 1'b0;
    mvs_prev   = 1'b0;
  endtask

  // Drive one clock of input, advance the model, capture any output window after the edge.
  task automatic step(input logic vs, input logic hr, input logic ce, input logic [7:0] d);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_data    = d;
    if (hr && ce && (mcol < H)) begin
      hist[0][mcol] = d;
      exp_q.push_back(model_window(mcol, mrow));
      mcol++;
    end
    if (mhref_prev && !hr) begin
      for (int i = 0; i < H; i++) begin
        hist[2][i] = hist[1][i];
        hist[1][i] = hist[0][i];
      end
      mcol = 0;
      if (mrow < V) mrow++;
    end
    if (!mvs_prev && vs) mrow = 0;
    mhref_prev = hr;
    mvs_prev   = vs;
    @(negedge clk);
    if (matrix_frame_clken) obs_q.push_back({matrix_border, matrix_data});
  endtask

  task automatic start_frame();
    exp_q.delete();
    obs_q.delete();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_line();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_data    = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (matrix_data !== 72'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h expected 0", matrix_data);
    end
    checks++;
    if (matrix_frame_clken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_clken got %b expected 0", matrix_frame_clken);
    end
    checks++;
    if (matrix_border !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_border got %b expected 0", matrix_border);
    end
    checks++;
    if (matrix_frame_vsync !== 1'b0 || matrix_frame_href !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sync got vs=%b hr=%b expected 0 0", matrix_frame_vsync, matrix_frame_href);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Deterministic frame, pixel = row*16 + col.
  task automatic test_frame();
    start_frame();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++)
        step(1'b0, 1'b1, 1'b1, 8'(y*16 + x));
      end_line();
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL frame_count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL frame_window[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== {1'b1, 72'h0}) begin
      errors++;
      $display("[TB] FAIL frame_rep_00 got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 73'h0, {1'b1, 72'h0});
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1] !== {1'b1, 72'h000001000001000001}) begin
      errors++;
      $display("[TB] FAIL frame_rep_10 got %h expected %h", (obs_q.size() > 1) ? obs_q[1] : 73'h0,
               {1'b1, 72'h000001000001000001});
    end
`else
    checks++;
    if (obs_q.size() < 11 || obs_q[10] !== {1'b0, 72'h000102101112202122}) begin
      errors++;
      $display("[TB] FAIL frame_zero_22 got %h expected %h", (obs_q.size() > 10) ? obs_q[10] : 73'h0,
               {1'b0, 72'h000102101112202122});
    end
`endif
  endtask

  task automatic test_latency();
    logic       vs_hist [20];
    logic       hr_hist [20];
    logic [7:0] d;
    start_frame();
    d = 8'($urandom);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, d);
    checks++;
    if (matrix_frame_clken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_n1 got %b expected 0", matrix_frame_clken);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (matrix_frame_clken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_n2 got %b expected 1", matrix_frame_clken);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (matrix_frame_clken !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_n3 got %b expected 0", matrix_frame_clken);
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL latency_window got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 73'h0,
               (exp_q.size() > 0) ? exp_q[0] : 73'h0);
    end
    end_line();
    for (int i = 0; i < 20; i++) begin
      vs_hist[i] = 1'($urandom);
      hr_hist[i] = 1'($urandom);
      step(vs_hist[i], hr_hist[i], 1'b0, 8'h00);
      if (i > 0) begin
        checks++;
        if (matrix_frame_vsync !== vs_hist[i-1] || matrix_frame_href !== hr_hist[i-1]) begin
          errors++;
          $display("[TB] FAIL sync_delay[%0d] got vs=%b hr=%b expected vs=%b hr=%b", i,
                   matrix_frame_vsync, matrix_frame_href, vs_hist[i-1], hr_hist[i-1]);
        end
      end
    end
    end_line();
  endtask

  // Random strobe gaps and random pixels over 4 lines (row saturates on the last one).
  task automatic test_gaps();
    int got;
    int budget;
    start_frame();
    for (int y = 0; y < V + 1; y++) begin
      got    = 0;
      budget = 0;
      while (got < H && budget < 100) begin
        if ($urandom_range(0, 2) == 0) begin
          step(1'b0, 1'b1, 1'b0, 8'($urandom));
        end else begin
          step(1'b0, 1'b1, 1'b1, 8'($urandom));
          got++;
        end
        budget++;
      end
      end_line();
    end
    checks++;
    if (obs_q.size() != (V + 1) * H || exp_q.size() != (V + 1) * H) begin
      errors++;
      $display("[TB] FAIL gaps_count got %0d expected %0d", obs_q.size(), (V + 1) * H);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL gaps_window[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // Line of H+2 strobes: the extra two must be dropped and must not disturb the next line.
  task automatic test_overflow();
    start_frame();
    for (int x = 0; x < H + 2; x++)
      step(1'b0, 1'b1, 1'b1, 8'($urandom));
    end_line();
    for (int x = 0; x < H; x++)
      step(1'b0, 1'b1, 1'b1, 8'($urandom));
    end_line();
    checks++;
    if (obs_q.size() != 2 * H) begin
      errors++;
      $display("[TB] FAIL overflow_count got %0d expected %0d", obs_q.size(), 2 * H);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL overflow_window[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  d0;
    logic [72:0] first;
    start_frame();
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < H; x++)
        step(1'b0, 1'b1, 1'b1, 8'($urandom));
      end_line();
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
    d0 = 8'($urandom_range(1, 255));
    step(1'b0, 1'b1, 1'b1, d0);
    for (int x = 1; x < H; x++)
      step(1'b0, 1'b1, 1'b1, 8'($urandom));
    end_line();
`ifdef VIP_MATRIX_BORDER_REPLICATE_EN
    first = {1'b1, {9{d0}}};
`else
    first = {1'b1, 64'h0, d0};
`endif
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== first) begin
      errors++;
      $display("[TB] FAIL rst_first_window got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 73'h0, first);
    end
    checks++;
    if (obs_q.size() != H) begin
      errors++;
      $display("[TB] FAIL rst_count got %0d expected %0d", obs_q.size(), H);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rst_window[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_latency();
    test_gaps();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
